csa_seq_block_adder: RTL and testbench

//  Multi-cycle carry-select adder: adds two WIDTH-bit operands one BLOCK-bit slice per clock.

---
 rtl/csa_seq_block_adder_if.sv | 43 ++++
 rtl/csa_seq_block_adder.sv | 142 ++++++++++++++
 tb/tb_csa_seq_block_adder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_seq_block_adder_if.sv
// Operand/result bus for csa_seq_block_adder.
// Optional SIGNED_OVF_EN adds the ovf signal to the result side.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds valid and its payload steady until that
// edge, and valid never waits on ready. Ready may depend on the consumer's
// state only.
interface csa_seq_block_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SIGNED_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/csa_seq_block_adder.sv
// Multi-cycle carry-select adder: one BLOCK-bit slice per clock.
// Both slice sums (carry-in 0 and 1) are formed every RUN cycle and the
// registered carry picks one, so the carry register closes the select loop.
// Optional feature: define SIGNED_OVF_EN to add the signed overflow output.
module csa_seq_block_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    csa_seq_block_adder_if.slave bus,
    output logic [1:0]           dbg_state
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int IDXW = (NBLK > 1) ? $clog2(NBLK) : 1;

    // Illegal geometry stops elaboration.
    if (BLOCK < 1) begin : g_bad_block
        $fatal(1, "csa_seq_block_adder: BLOCK must be >= 1");
    end else if ((WIDTH % BLOCK) != 0) begin : g_bad_width
        $fatal(1, "csa_seq_block_adder: WIDTH must be a multiple of BLOCK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SIGNED_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    int               base;
    logic [BLOCK-1:0] a_sl, b_sl;
    logic [BLOCK:0]   s0, s1;
    logic [BLOCK-1:0] sel_sum;
    logic             sel_c;

    // Current slice: both candidate sums and the carry-selected result.
    always_comb begin
        base    = int'(idx_q) * BLOCK;
        a_sl    = a_q[base +: BLOCK];
        b_sl    = b_q[base +: BLOCK];
        s0      = {1'b0, a_sl} + {1'b0, b_sl};
        s1      = s0 + (BLOCK+1)'(1);
        sel_sum = carry_q ? s1[BLOCK-1:0] : s0[BLOCK-1:0];
        sel_c   = carry_q ? s1[BLOCK] : s0[BLOCK];
    end

    // Next-state and datapath updates for IDLE -> RUN -> DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SIGNED_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    carry_d = bus.cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[base +: BLOCK] = sel_sum;
                carry_d              = sel_c;
                idx_d                = idx_q + IDXW'(1);
                if (idx_q == IDXW'(NBLK - 1)) begin
                    cout_d  = sel_c;
`ifdef SIGNED_OVF_EN
                    // Carry into the MSB is recovered from the selected sum bit.
                    ovf_d   = (sel_sum[BLOCK-1] ^ a_sl[BLOCK-1] ^ b_sl[BLOCK-1]) ^ sel_c;
`endif
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any add in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SIGNED_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
`ifdef SIGNED_OVF_EN
    assign bus.ovf       = ovf_q;
`endif
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_csa_seq_block_adder.sv
// Bench for csa_seq_block_adder at WIDTH=16, BLOCK=4.
module tb_csa_seq_block_adder;
    localparam int WIDTH = 16;
    localparam int BLOCK = 4;
    localparam int NBLK  = WIDTH / BLOCK;
    localparam int NRAND = 1000;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    csa_seq_block_adder_if #(.WIDTH(WIDTH)) bus_if ();

    csa_seq_block_adder #(
        .WIDTH(WIDTH),
        .BLOCK(BLOCK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus_if),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int             n_cmp = 0;
    int             n_bad = 0;
    logic [WIDTH:0] exp_q[$];

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_ovf();
`ifdef SIGNED_OVF_EN
        return bus_if.ovf;
`else
        return 1'b0;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_in_ready();
        int guard = 0;
        while (!bus_if.in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", 32'(bus_if.in_ready), 32'd1);
    endtask

    task automatic wait_out_valid(output int lat);
        lat = 0;
        while (!bus_if.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // One complete add: handshake in, measure latency, take the result.
    task automatic do_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                          output logic [WIDTH-1:0] got_sum, output logic got_cout,
                          output logic got_ovf, output int lat);
        @(negedge clk);
        wait_in_ready();
        bus_if.in_valid = 1'b1;
        bus_if.a        = a;
        bus_if.b        = b;
        bus_if.cin      = cin;
        @(negedge clk);
        // Scramble operands after the accepting edge; they must not be resampled.
        bus_if.in_valid = 1'b0;
        bus_if.a        = WIDTH'($urandom);
        bus_if.b        = WIDTH'($urandom);
        bus_if.cin      = 1'($urandom_range(0, 1));
        wait_out_valid(lat);
        got_sum  = bus_if.sum;
        got_cout = bus_if.cout;
        got_ovf  = get_ovf();
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [WIDTH-1:0] gs;
        logic             gc;
        logic             go;
        int               lat;
        int               issued;
        int               done;
        int               cyc;
        logic             ordy;
        logic             iv;
        logic [WIDTH:0]   exp_v;

        bus_if.in_valid  = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.cin       = 1'b0;
        bus_if.out_ready = 1'b0;
        rst_n            = 1'b0;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[7] = '{16'h0003, 16'hFFFF, 1'b0, 16'h0002, 1'b1, 1'b0};
        vecs[8] = '{16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0};
        vecs[9] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(bus_if.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_sum",       32'(bus_if.sum),       32'd0);
        check("rst_cout",      32'(bus_if.cout),      32'd0);
        check("rst_state",     32'(dbg_state),        32'd0);
`ifdef SIGNED_OVF_EN
        check("rst_ovf",       32'(bus_if.ovf),       32'd0);
`endif
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            do_add(vecs[i].a, vecs[i].b, vecs[i].cin, gs, gc, go, lat);
            check($sformatf("vec%0d_sum", i),     32'(gs),  32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i),    32'(gc),  32'(vecs[i].exp_cout));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(NBLK));
`ifdef SIGNED_OVF_EN
            check($sformatf("vec%0d_ovf", i),     32'(go),  32'(vecs[i].exp_ovf));
`endif
            check($sformatf("vec%0d_idle_after", i), 32'(bus_if.in_ready), 32'd1);
            check($sformatf("vec%0d_ov_drop", i),    32'(bus_if.out_valid), 32'd0);
        end

        // Backpressure: result held while out_ready stays low, new operands ignored
        @(negedge clk);
        wait_in_ready();
        bus_if.in_valid = 1'b1;
        bus_if.a        = 16'h1234;
        bus_if.b        = 16'h4321;
        bus_if.cin      = 1'b1;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        wait_out_valid(lat);
        check("bp_latency", 32'(lat), 32'(NBLK));
        for (int i = 0; i < 10; i++) begin
            bus_if.in_valid = i[0];
            bus_if.a        = 16'hAAAA;
            bus_if.b        = 16'h5555;
            bus_if.cin      = 1'b1;
            @(negedge clk);
            check($sformatf("bp_sum_c%0d", i),      32'(bus_if.sum),       32'h5556);
            check($sformatf("bp_cout_c%0d", i),     32'(bus_if.cout),      32'd0);
            check($sformatf("bp_in_ready_c%0d", i), 32'(bus_if.in_ready),  32'd0);
            check($sformatf("bp_valid_c%0d", i),    32'(bus_if.out_valid), 32'd1);
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b0;
        check("bp_release_idle",  32'(bus_if.in_ready),  32'd1);
        check("bp_release_valid", 32'(bus_if.out_valid), 32'd0);
        check("bp_release_sum",   32'(bus_if.sum),       32'h5556);

        // Reset in the middle of RUN
        @(negedge clk);
        wait_in_ready();
        bus_if.in_valid = 1'b1;
        bus_if.a        = 16'h1234;
        bus_if.b        = 16'h4321;
        bus_if.cin      = 1'b1;
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_state_run", 32'(dbg_state), 32'd1);
        check("mid_sum_partial", 32'(bus_if.sum), 32'h0056);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum",       32'(bus_if.sum),       32'd0);
        check("mid_rst_cout",      32'(bus_if.cout),      32'd0);
        check("mid_rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(bus_if.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        do_add(16'hFFFF, 16'h0001, 1'b0, gs, gc, go, lat);
        check("post_rst_sum",     32'(gs),  32'h0000);
        check("post_rst_cout",    32'(gc),  32'd1);
        check("post_rst_latency", 32'(lat), 32'(NBLK));

        // Random operands with random out_ready stalls
        issued = 0;
        done   = 0;
        cyc    = 0;
        while (done < NRAND && cyc < NRAND * 20) begin
            @(negedge clk);
            cyc++;
            ordy = ($urandom_range(0, 3) != 0);
            if (bus_if.out_valid && ordy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rand_extra_result: got sum 0x%0h with no accepted input", bus_if.sum);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("rand_result", 32'({bus_if.cout, bus_if.sum}), 32'(exp_v));
                end
                done++;
            end
            bus_if.out_ready = ordy;
            iv = ($urandom_range(0, 1) == 1) && (issued < NRAND);
            bus_if.in_valid = iv;
            bus_if.a        = WIDTH'($urandom);
            bus_if.b        = WIDTH'($urandom);
            bus_if.cin      = 1'($urandom_range(0, 1));
            if (iv && bus_if.in_ready) begin
                exp_q.push_back((WIDTH+1)'(bus_if.a) + (WIDTH+1)'(bus_if.b) + (WIDTH+1)'(bus_if.cin));
                issued++;
            end
        end
        @(negedge clk);
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        check("rand_results_seen", 32'(done), 32'(NRAND));
        check("rand_issued",       32'(issued), 32'(NRAND));
        check("rand_queue_empty",  32'(exp_q.size()), 32'd0);

        // Final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
